id_debug_reg_dump: RTL

- Debug-side neighbour of the ID register file. Drives the file's debug read address and consumes its debug read data.
- On a start request it walks registers 0..SIZE_REG-1 and serialises each word into bytes over a valid/ready byte stream toward the debug UART TX.
- Sits between the debug unit's command decoder and the register file's debug read port.

---
 rtl/id_debug_reg_dump_if.sv | 31 +++
 rtl/id_debug_reg_dump.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_debug_reg_dump_if.sv
// Debug-side bus bundle for id_debug_reg_dump.
// Carries the register file debug read port (address out, combinational data
// back) and the valid/ready byte stream toward the debug UART TX.
// master: the dump engine. slave: register file + TX side.
interface id_debug_reg_dump_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
);
  logic [NB_REG-1:0]  address_read_debug;
  logic [NB_DATA-1:0] data_read_debug;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output address_read_debug,
    output tx_data,
    output tx_valid,
    input  data_read_debug,
    input  tx_ready
  );

  modport slave (
    input  address_read_debug,
    input  tx_data,
    input  tx_valid,
    output data_read_debug,
    output tx_ready
  );
endinterface

// File: rtl/id_debug_reg_dump.sv
// id_debug_reg_dump: walks registers 0..SIZE_REG-1 of the ID register file
// through its debug read port and serialises each word, least-significant
// byte first, onto a valid/ready byte stream for the debug UART TX.
// All outputs are registered.
// Optional feature (macro DUMP_CHECKSUM_EN): after the last register byte an
// extra byte carrying the XOR of every byte sent is emitted.
module id_debug_reg_dump #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int SIZE_REG = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  id_debug_reg_dump_if.master dbg,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX  = NB_IDX'(NB_BYTES - 1);
  localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NB_REG-1:0]  addr_q, addr_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

  logic               hs;
  logic [NB_DATA-1:0] shift_next;

  // A byte leaves on any edge where it is offered and TX is ready.
  assign hs         = tx_valid_q & dbg.tx_ready;
  assign shift_next = shift_q >> NB_BYTE;

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      // The register file answers combinationally, so the word for the
      // current address is captured here, in this single cycle.
      S_LOAD: begin
        shift_d    = dbg.data_read_debug;
        tx_data_d  = dbg.data_read_debug[NB_BYTE-1:0];
        tx_valid_d = 1'b1;
        idx_d      = '0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (hs) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 1'b1;
            shift_d   = shift_next;
            tx_data_d = shift_next[NB_BYTE-1:0];
          end else begin
            tx_valid_d = 1'b0;
            if (addr_q != LAST_ADDR) begin
              addr_d  = addr_q + 1'b1;
              state_d = S_LOAD;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end

`ifdef DUMP_CHECKSUM_EN
      // First cycle presents the accumulator; it then waits for its handshake.
      S_CSUM: begin
        if (!tx_valid_q) begin
          tx_data_d  = csum_q;
          tx_valid_d = 1'b1;
        end else if (hs) begin
          tx_valid_d = 1'b0;
          state_d    = S_DONE;
        end
      end
`endif

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE; a byte handshaken on the
    // same edge has still been taken by TX.
    if (i_abort && (state_q != S_IDLE)) begin
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      state_d    = S_IDLE;
    end
  end

  // State and output registers; reset discards any dump in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign dbg.address_read_debug = addr_q;
  assign dbg.tx_data            = tx_data_q;
  assign dbg.tx_valid           = tx_valid_q;
  assign o_busy                 = busy_q;
  assign o_done                 = done_q;

endmodule
